// File: rtl/vend_pkg.sv
// vend_pkg: shared types, coin values, price and change codes for the vending FSM
package vend_pkg;
  typedef enum logic {CREDIT = 1'b0, VEND = 1'b1} state_t;
  localparam logic [3:0] FARTHING = 4'd1;
  localparam logic [3:0] HAPENNY = 4'd2;
  localparam logic [3:0] PENNY = 4'd4;
  localparam logic [3:0] PRICE = 4'd5;
  localparam logic [3:0] CHG_F = 4'd6;
  localparam logic [3:0] CHG_H = 4'd7;
  localparam logic [3:0] CHG_HF = 4'd8;
  localparam logic [1:0] WARM_CYCLES = 2'd3;
  function automatic logic [3:0] coin_value(input logic f, input logic h, input logic p);
    return f ? FARTHING : h ? HAPENNY : p ? PENNY : 4'd0;
  endfunction
  function automatic logic [1:0] coin_count(input logic f, input logic h, input logic p);
    return {1'b0, f} + {1'b0, h} + {1'b0, p};
  endfunction
endpackage

// File: rtl/vend_fsm_edge_sync.sv
// edge_sync: two-flop synchronizer followed by a one-cycle rising-edge pulse
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic s1, s2, s3;
  // synchronize the raw switch level and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {d, s1, s2};
  assign pulse = s2 & ~s3;
endmodule

// File: rtl/vend_fsm.sv
// vend_fsm: coin-accepting vending controller with timed vend/change hold
module vend_fsm
  import vend_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f_in,
  input  logic       h_in,
  input  logic       p_in,
  output logic [3:0] code,
  output logic       vend,
  output logic       busy
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  state_t state, nxt_state;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] warm, warm_d;
  logic [3:0] code_d, sum;
  logic vend_d, busy_d, f_p, h_p, p_p, accept, expire;
  edge_sync u_f (.clk(clk), .reset(reset), .d(f_in), .pulse(f_p));
  edge_sync u_h (.clk(clk), .reset(reset), .d(h_in), .pulse(h_p));
  edge_sync u_p (.clk(clk), .reset(reset), .d(p_in), .pulse(p_p));
  assign accept = state == CREDIT && warm == 2'd0 && coin_count(f_p, h_p, p_p) == 2'd1;
  assign expire = state == VEND && cnt == LAST;
  assign sum = code + coin_value(f_p, h_p, p_p);
  // state and all outputs are registered; reset starts the warm-up window
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CREDIT;
      cnt <= '0;
      warm <= WARM_CYCLES;
      code <= 4'd0;
      vend <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= nxt_state;
      cnt <= cnt_d;
      warm <= warm_d;
      code <= code_d;
      vend <= vend_d;
      busy <= busy_d;
    end
  // enter VEND once credit reaches the price, leave when the hold expires
  always_comb
    nxt_state = state == CREDIT ? ((accept && sum >= PRICE) ? VEND : CREDIT) :
                (expire ? CREDIT : VEND);
  // next output values: coins during VEND or expiry are simply dropped
  always_comb begin
    code_d = expire ? 4'd0 : accept ? sum : code;
    cnt_d = (state == VEND && !expire) ? cnt + CW'(1) : '0;
    warm_d = warm != 2'd0 ? warm - 2'd1 : 2'd0;
    vend_d = nxt_state == VEND;
    busy_d = nxt_state == VEND || warm_d != 2'd0;
  end
endmodule

// File: doc/vend_fsm.md
VEND_FSM -- requirements
Module: vend_fsm

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, the number of clk cycles a vend/change code is held for display (minimum 2).
REQ-002 SHALL have port clk  input  1  the single system clock; all state is on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port f_in  input  1  farthing coin switch (1 farthing), asynchronous level, active-high.
REQ-005 SHALL have port h_in  input  1  ha'penny coin switch (2 farthings), asynchronous level, active-high.
REQ-006 SHALL have port p_in  input  1  penny coin switch (4 farthings), asynchronous level, active-high.
REQ-007 SHALL have port code  output  4  credit/state code in farthings, 0..8; feeds the change display decoder (6 = farthing change, 7 = ha'penny change, 8 = ha'penny + farthing change).
REQ-008 SHALL have port vend  output  1  high while an item is being dispensed (code >= 5).
REQ-009 SHALL have port busy  output  1  high while coins are being ignored (vend hold or post-reset warm-up).

Function
REQ-010 SHALL pass each coin input through a 2-flop synchronizer followed by a rising-edge detector, giving one accepted pulse per press.
REQ-011 SHALL update code on the 3rd rising clk edge after a coin input goes high: two synchronizer edges, then the register update.
REQ-012 SHALL implement two states: CREDIT (code 0..4, accepting coins) and VEND (code 5..8, holding).
REQ-013 In CREDIT, one accepted coin SHALL set code = code + coin value; if the result is >= 5 (the item price), the state SHALL go to VEND with vend = 1.
REQ-014 In CREDIT, if two or more coin pulses occur in the same cycle, all of them SHALL be ignored and code SHALL stay unchanged.
REQ-015 In VEND, code SHALL stay constant for exactly HOLD_CYCLES cycles; then code, vend and busy SHALL return to 0 on the same edge and the state SHALL go to CREDIT.
REQ-016 Coin pulses in VEND SHALL be discarded; they SHALL NOT be queued or credited after the hold ends.
REQ-017 A coin pulse in the same cycle as hold expiry SHALL be discarded.
REQ-018 The hold counter SHALL be wide enough for HOLD_CYCLES and SHALL never wrap; code SHALL never exceed 8 (the maximum is 4 + penny).
REQ-019 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-020 Reset SHALL set code = 0, vend = 0, state = CREDIT, hold counter = 0, and all synchronizer and edge flops = 0.
REQ-021 For 3 cycles after reset deasserts, busy SHALL be 1 and coin pulses SHALL be ignored, so an input held high through reset is not credited.
REQ-022 Reset during VEND SHALL abort the hold immediately; no change code SHALL reappear afterwards.

Structure
REQ-023 A shared package vend_pkg SHALL hold the state enum (CREDIT, VEND), the coin values (FARTHING = 1, HAPENNY = 2, PENNY = 4), PRICE = 5, and the change codes 6/7/8.
REQ-024 A sub-module edge_sync (2-flop synchronizer plus rising-edge pulse, async active-high reset) SHALL be instantiated once per coin input.

Verification
REQ-025 Bench SHALL run with HOLD_CYCLES = 8 and cover these scenarios:
- Reset, wait 4 cycles, press f, h, h, one press each -> code 1, 3, then 5 with vend = 1; back to 0 after 8 cycles.
- Press h, h, p -> code 2, 4, then 8 with vend = 1 (ha'penny + farthing change); after 8 cycles code = 0.
- Press p, then p again during the hold -> code 4, then 8 for 8 cycles, then 0; the second-p credit is never seen afterwards.
- Press f and h in the same cycle from code 0 -> code stays 0; a single h press afterwards -> code 2.
- Hold p high through reset release -> code stays 0 and busy = 1 for 3 cycles; a later p release and re-press -> code 4.
- Assert reset mid-hold at code 7 -> code = 0 and vend = 0 asynchronously; no 7 appears after reset.
